// File: rtl/dica_pkg.sv
// dica_pkg: shared definitions for the hint decoder.
//   LARGURA  : password / guess / hint width in bits.
//   op_e     : hint operation codes (6 and 7 are invalid).
//   estado_e : decoder states.
package dica_pkg;
   localparam int LARGURA = 7;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5
   } op_e;

   typedef enum logic [2:0] {
      OCIOSO    = 3'd0,
      ACUMULA   = 3'd1,
      PROCESSA  = 3'd2,
      RESOLVIDO = 3'd3,
      ERRO      = 3'd4
   } estado_e;
endpackage

// File: rtl/dica_extrator.sv
// dica_extrator: combinational decode of one hint into the password bits it
// reveals (mask) and their values (valor).
//   operacao_i  : hint operation code
//   dica_i      : hint value
//   tentativa_i : guess that produced the hint
//   mask_o      : bits of the password revealed by this hint
//   valor_o     : values of the revealed bits (meaningful under mask_o only)
//   invalida_o  : operation code 6/7
module dica_extrator
   import dica_pkg::*;
(
   input  logic [2:0]         operacao_i,
   input  logic [LARGURA-1:0] dica_i,
   input  logic [LARGURA-1:0] tentativa_i,
   output logic [LARGURA-1:0] mask_o,
   output logic [LARGURA-1:0] valor_o,
   output logic               invalida_o
);
   always_comb begin
      mask_o     = '0;
      valor_o    = '0;
      invalida_o = 1'b0;
      case (operacao_i)
         OP_AND:  begin mask_o = tentativa_i;  valor_o = dica_i;                  end
         OP_OR:   begin mask_o = ~tentativa_i; valor_o = dica_i;                  end
         OP_NAND: begin mask_o = tentativa_i;  valor_o = ~dica_i;                 end
         OP_NOR:  begin mask_o = ~tentativa_i; valor_o = ~dica_i;                 end
         OP_XOR:  begin mask_o = '1;           valor_o = dica_i ^ tentativa_i;    end
         OP_XNOR: begin mask_o = '1;           valor_o = ~(dica_i ^ tentativa_i); end
         default: invalida_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/decodificador_dica.sv
// decodificador_dica: rebuilds the hidden password from a stream of hints,
// accumulating a known-bit mask and proposing the next guess.
//   clk, reset_n       : clock (rising edge), async active-low reset
//   limpar             : synchronous clear back to the empty state
//   dica_valid/ready   : hint handshake (dica, tentativa, operacao)
//   conhecido          : mask of determined password bits
//   senha_parcial      : determined bit values (0 outside conhecido)
//   proxima_tentativa  : suggested next guess
//   resolvido, erro    : fully determined / contradiction seen
//   op_invalida        : pulse while an invalid-code hint is processed
//   n_dicas            : accepted valid hints, saturating at 15
// Build option: DICA_CONTRADICAO_EN enables the contradiction check and the
// ERRO state; without it newer hints simply overwrite known bits.
module decodificador_dica
   import dica_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               limpar,
   input  logic               dica_valid,
   output logic               dica_ready,
   input  logic [LARGURA-1:0] dica,
   input  logic [LARGURA-1:0] tentativa,
   input  logic [2:0]         operacao,
   output logic [LARGURA-1:0] conhecido,
   output logic [LARGURA-1:0] senha_parcial,
   output logic [LARGURA-1:0] proxima_tentativa,
   output logic               resolvido,
   output logic               erro,
   output logic               op_invalida,
   output logic [3:0]         n_dicas
);
   estado_e            estado_q, estado_d;
   logic [LARGURA-1:0] mask_q, mask_d, valor_q, valor_d;
   logic               inv_q, inv_d;
   logic [LARGURA-1:0] conh_q, conh_d, sp_q, sp_d, prox_q, prox_d;
   logic               fase_q, fase_d, opinv_q, opinv_d;
   logic [3:0]         ndicas_q, ndicas_d;

   logic [LARGURA-1:0] mask_w, valor_w, conh_novo, sp_novo;
   logic               inv_w, conflito;

   // Decode at acceptance; PROCESSA then works from the registered result.
   dica_extrator u_extrator (
      .operacao_i  (operacao),
      .dica_i      (dica),
      .tentativa_i (tentativa),
      .mask_o      (mask_w),
      .valor_o     (valor_w),
      .invalida_o  (inv_w)
   );

   assign conh_novo = conh_q | mask_q;
   assign sp_novo   = (sp_q & ~mask_q) | (valor_q & mask_q);

`ifdef DICA_CONTRADICAO_EN
   assign conflito = |(conh_q & mask_q & (sp_q ^ valor_q));
   assign erro     = (estado_q == ERRO);
`else
   assign conflito = 1'b0;
   assign erro     = 1'b0;
`endif

   // Outputs are decodes of registers only.
   assign dica_ready        = (estado_q == OCIOSO) || (estado_q == ACUMULA);
   assign conhecido         = conh_q;
   assign senha_parcial     = sp_q;
   assign proxima_tentativa = prox_q;
   assign resolvido         = &conh_q;
   assign op_invalida       = opinv_q;
   assign n_dicas           = ndicas_q;

   always_comb begin
      estado_d = estado_q;
      mask_d   = mask_q;
      valor_d  = valor_q;
      inv_d    = inv_q;
      conh_d   = conh_q;
      sp_d     = sp_q;
      prox_d   = prox_q;
      fase_d   = fase_q;
      ndicas_d = ndicas_q;
      opinv_d  = 1'b0;
      if (limpar) begin
         estado_d = OCIOSO;
         mask_d   = '0;
         valor_d  = '0;
         inv_d    = 1'b0;
         conh_d   = '0;
         sp_d     = '0;
         prox_d   = '1;
         fase_d   = 1'b1;
         ndicas_d = '0;
      end else begin
         case (estado_q)
            OCIOSO, ACUMULA: begin
               if (dica_valid) begin
                  mask_d   = mask_w;
                  valor_d  = valor_w;
                  inv_d    = inv_w;
                  opinv_d  = inv_w;
                  estado_d = PROCESSA;
               end
            end
            PROCESSA: begin
               if (inv_q) begin
                  estado_d = (conh_q == '0) ? OCIOSO : ACUMULA;
               end else begin
                  ndicas_d = (ndicas_q == 4'hF) ? ndicas_q : ndicas_q + 4'd1;
                  // Alternating fill makes AND-type and OR-type guesses
                  // take turns exposing the still-unknown bits.
                  fase_d   = ~fase_q;
                  if (conflito) begin
                     estado_d = ERRO;
                  end else begin
                     conh_d   = conh_novo;
                     sp_d     = sp_novo;
                     prox_d   = (sp_novo & conh_novo) | (~conh_novo & {LARGURA{~fase_q}});
                     estado_d = (&conh_novo) ? RESOLVIDO : ACUMULA;
                  end
               end
            end
            RESOLVIDO, ERRO: estado_d = estado_q;
            default:         estado_d = OCIOSO;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= OCIOSO;
         mask_q   <= '0;
         valor_q  <= '0;
         inv_q    <= 1'b0;
         conh_q   <= '0;
         sp_q     <= '0;
         prox_q   <= '1;
         fase_q   <= 1'b1;
         ndicas_q <= '0;
         opinv_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         mask_q   <= mask_d;
         valor_q  <= valor_d;
         inv_q    <= inv_d;
         conh_q   <= conh_d;
         sp_q     <= sp_d;
         prox_q   <= prox_d;
         fase_q   <= fase_d;
         ndicas_q <= ndicas_d;
         opinv_q  <= opinv_d;
      end
   end
endmodule

// File: tb/tb_decodificador_dica.sv
module tb_decodificador_dica;
   logic       clk = 1'b0;
   logic       reset_n, limpar, dica_valid, dica_ready;
   logic [6:0] dica, tentativa, conhecido, senha_parcial, proxima_tentativa;
   logic [2:0] operacao;
   logic       resolvido, erro, op_invalida;
   logic [3:0] n_dicas;

   decodificador_dica dut (
      .clk(clk), .reset_n(reset_n), .limpar(limpar),
      .dica_valid(dica_valid), .dica_ready(dica_ready),
      .dica(dica), .tentativa(tentativa), .operacao(operacao),
      .conhecido(conhecido), .senha_parcial(senha_parcial),
      .proxima_tentativa(proxima_tentativa), .resolvido(resolvido),
      .erro(erro), .op_invalida(op_invalida), .n_dicas(n_dicas)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: what the solver knows about the password.
   logic [6:0] m_con, m_sp;
   logic       m_fase, m_err;
   int         m_n;

`ifdef DICA_CONTRADICAO_EN
   localparam bit CONTRA = 1'b1;
`else
   localparam bit CONTRA = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One bit of the hint operation applied to password bit s and guess bit t.
   function automatic logic opb(input int op, input logic s, input logic t);
      case (op)
         0: return s & t;
         1: return s | t;
         2: return ~(s & t);
         3: return ~(s | t);
         4: return s ^ t;
         default: return ~(s ^ t);
      endcase
   endfunction

   function automatic logic [6:0] gera_dica(input int op, input logic [6:0] s, input logic [6:0] t);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = opb(op, s[i], t[i]);
      return r;
   endfunction

   function automatic logic [6:0] m_prox();
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = m_con[i] ? m_sp[i] : m_fase;
      return r;
   endfunction

   function automatic bit m_ready();
      return !(m_err || (m_con == 7'h7F));
   endfunction

   task automatic m_reset();
      m_con = '0; m_sp = '0; m_fase = 1'b1; m_err = 1'b0; m_n = 0;
   endtask

   // A password bit is learned when flipping it would change the hint bit.
   task automatic m_aplica(input int op, input logic [6:0] t, input logic [6:0] d);
      logic [6:0] nm, nv;
      bit conf;
      if (op > 5) return;
      conf = 1'b0;
      for (int i = 0; i < 7; i++) begin
         nm[i] = (opb(op, 1'b0, t[i]) != opb(op, 1'b1, t[i]));
         nv[i] = (d[i] == opb(op, 1'b1, t[i]));
         if (nm[i] && m_con[i] && (m_sp[i] != nv[i])) conf = 1'b1;
      end
      if (m_n < 15) m_n++;
      m_fase = ~m_fase;
      if (conf && CONTRA) begin
         m_err = 1'b1;
      end else begin
         for (int i = 0; i < 7; i++)
            if (nm[i]) begin m_con[i] = 1'b1; m_sp[i] = nv[i]; end
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".conhecido"}, 32'(conhecido), 32'(m_con));
      chk({tag, ".senha"}, 32'(senha_parcial), 32'(m_sp));
      chk({tag, ".prox"}, 32'(proxima_tentativa), 32'(m_prox()));
      chk({tag, ".resolvido"}, 32'(resolvido), 32'(m_con == 7'h7F));
      chk({tag, ".erro"}, 32'(erro), 32'(m_err));
      chk({tag, ".n_dicas"}, 32'(n_dicas), 32'(m_n));
      chk({tag, ".ready"}, 32'(dica_ready), 32'(m_ready()));
      chk({tag, ".op_inv"}, 32'(op_invalida), 32'd0);
   endtask

   task automatic envia(input string tag, input int op, input logic [6:0] t, input logic [6:0] d);
      dica_valid = 1'b1; operacao = 3'(op); tentativa = t; dica = d;
      step();
      dica_valid = 1'b0;
      chk({tag, ".ready_proc"}, 32'(dica_ready), 32'd0);
      chk({tag, ".op_inv_pulse"}, 32'(op_invalida), 32'(op > 5));
      m_aplica(op, t, d);
      step();
      check_all(tag);
   endtask

   task automatic limpa(input string tag);
      limpar = 1'b1;
      step();
      limpar = 1'b0;
      m_reset();
      check_all(tag);
   endtask

   initial begin
      logic [6:0] senha, t;
      int op, guard;
      reset_n = 1'b0; limpar = 1'b0; dica_valid = 1'b0;
      dica = '0; tentativa = '0; operacao = '0;
      m_reset();
      step(); step();
      reset_n = 1'b1;
      check_all("reset");

      // Whole password from a single XOR hint.
      envia("xor", 4, 7'h7F, 7'h26);
      chk("xor.senha_const", 32'(senha_parcial), 32'h59);
      limpa("limpar1");

      // AND then OR hints complete the password.
      envia("and", 0, 7'h0F, 7'h09);
      chk("and.prox_const", 32'(proxima_tentativa), 32'h09);
      envia("or", 1, 7'h00, 7'h59);
      limpa("limpar2");

      // Invalid operation from the empty state.
      envia("inv", 6, 7'h55, 7'h2A);
      envia("inv7", 7, 7'h11, 7'h22);

      // Contradicting hints (erro with the check, overwrite without).
      envia("c_and", 0, 7'h01, 7'h01);
      envia("c_xnor", 5, 7'h00, 7'h7F);
      limpa("limpar3");

      // Valid held for 4 edges: exactly two acceptances.
      dica_valid = 1'b1; operacao = 3'd0; tentativa = 7'h01; dica = 7'h01;
      step(); chk("hold.e0_ready", 32'(dica_ready), 32'd0);
      m_aplica(0, 7'h01, 7'h01);
      step(); chk("hold.e1_ready", 32'(dica_ready), 32'd1);
      step(); chk("hold.e2_ready", 32'(dica_ready), 32'd0);
      m_aplica(0, 7'h01, 7'h01);
      step();
      dica_valid = 1'b0;
      check_all("hold");
      step();
      check_all("hold_idle");

      // Saturation of n_dicas with hints that reveal nothing.
      for (int i = 0; i < 17; i++) envia("sat", 0, 7'h00, 7'h00);
      limpa("limpar4");

      // Random games from consistent hints of a random password.
      for (int g = 0; g < 8; g++) begin
         senha = 7'($urandom);
         guard = 0;
         while (m_ready() && guard < 12) begin
            op = $urandom_range(0, 7);
            t  = 7'($urandom);
            envia("rnd", op, t, (op < 6) ? gera_dica(op, senha, t) : 7'($urandom));
            guard++;
         end
         if (m_con == 7'h7F) chk("rnd.solved", 32'(senha_parcial), 32'(senha));
         limpa("rnd_limpar");
      end

      // Reset during PROCESSA drops the in-flight hint.
      dica_valid = 1'b1; operacao = 3'd4; tentativa = 7'h7F; dica = 7'h26;
      step();
      dica_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      m_reset();
      check_all("rst_proc");
      step();
      reset_n = 1'b1;
      step();
      check_all("rst_after");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
